// File: rtl/full_adder_structure_pkg.sv
// Shared constants for the structural ripple-carry adder.
// Latency constants cover both builds (with and without FULL_ADDER_STRUCTURE_INREG_EN).
package full_adder_structure_pkg;

  localparam int FAS_DEFAULT_WIDTH = 1;
  localparam int FAS_LATENCY_BASE  = 1;
  localparam int FAS_LATENCY_INREG = 2;

endpackage

// File: rtl/full_adder_structure_half.sv
// Half-adder cell: the leaf gate pair of the ripple-carry chain.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder_structure.sv
// Registered ripple-carry adder built from half-adder cells: {cout, s} = x + y + cin.
// Defining FULL_ADDER_STRUCTURE_INREG_EN adds an input register stage (latency 2 instead of 1).
module full_adder_structure
  import full_adder_structure_pkg::*;
#(
  parameter int WIDTH = FAS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             in_valid,
  output logic             cout,
  output logic [WIDTH-1:0] s,
  output logic             out_valid
);

  logic [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0] y_p0;
  logic             cin_p0;
  logic             vld_p0;

`ifdef FULL_ADDER_STRUCTURE_INREG_EN
  // Stage p0: optional input register; cleared on reset so nothing in flight survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0   <= '0;
      y_p0   <= '0;
      cin_p0 <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      x_p0   <= x;
      y_p0   <= y;
      cin_p0 <= cin;
      vld_p0 <= in_valid;
    end
  end
`else
  assign x_p0   = x;
  assign y_p0   = y;
  assign cin_p0 = cin;
  assign vld_p0 = in_valid;
`endif

  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] prop_p0;
  logic [WIDTH-1:0] gen_p0;
  logic [WIDTH-1:0] cgen_p0;
  logic [WIDTH-1:0] sum_p0;

  assign carry_p0[0] = cin_p0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha_xy (
      .a (x_p0[i]),
      .b (y_p0[i]),
      .s (prop_p0[i]),
      .c (gen_p0[i])
    );

    half_adder u_ha_c (
      .a (prop_p0[i]),
      .b (carry_p0[i]),
      .s (sum_p0[i]),
      .c (cgen_p0[i])
    );

    assign carry_p0[i+1] = gen_p0[i] | cgen_p0[i];
  end

  // Stage p1: result register. The ternary hold lets an X on in_valid reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout      <= 1'b0;
      s         <= '0;
      out_valid <= 1'b0;
    end else begin
      cout      <= vld_p0 ? carry_p0[WIDTH] : cout;
      s         <= vld_p0 ? sum_p0 : s;
      out_valid <= vld_p0;
    end
  end

endmodule

// File: tb/tb_full_adder_structure.sv
// Randomized bench for full_adder_structure at WIDTH=1 and WIDTH=4 against an arithmetic model.
module tb_full_adder_structure;
  import full_adder_structure_pkg::*;

`ifdef FULL_ADDER_STRUCTURE_INREG_EN
  localparam int LAT = FAS_LATENCY_INREG;
`else
  localparam int LAT = FAS_LATENCY_BASE;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x1 = 1'b0, y1 = 1'b0;
  logic [3:0] x4 = 4'h0, y4 = 4'h0;
  logic       cin = 1'b0;
  logic       in_valid = 1'b0;

  logic       cout1, s1, ov1;
  logic       cout4, ov4;
  logic [3:0] s4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  full_adder_structure #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .cin(cin), .in_valid(in_valid),
    .cout(cout1), .s(s1), .out_valid(ov1)
  );

  full_adder_structure #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .cin(cin), .in_valid(in_valid),
    .cout(cout4), .s(s4), .out_valid(ov4)
  );

  // Reference model: arithmetic sums of sampled inputs, delayed LAT edges, held when invalid.
  typedef struct {
    logic       vld;
    logic [1:0] r1;
    logic [4:0] r4;
  } samp_t;

  samp_t      hist[LAT];
  logic       exp_vld = 1'b0;
  logic [1:0] exp1 = 2'b00;
  logic [4:0] exp4 = 5'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) hist[k] = '{vld: 1'b0, r1: 2'b00, r4: 5'h00};
      exp_vld = 1'b0;
      exp1    = 2'b00;
      exp4    = 5'h00;
    end else begin
      for (int k = LAT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = '{vld: in_valid,
                  r1: 2'(x1) + 2'(y1) + 2'(cin),
                  r4: 5'(x4) + 5'(y4) + 5'(cin)};
      exp_vld = hist[LAT-1].vld;
      if (exp_vld) begin
        exp1 = hist[LAT-1].r1;
        exp4 = hist[LAT-1].r4;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  always @(negedge clk) begin
    check("model_vld1", 64'(ov1), 64'(exp_vld));
    check("model_sum1", 64'({cout1, s1}), 64'(exp1));
    check("model_vld4", 64'(ov4), 64'(exp_vld));
    check("model_sum4", 64'({cout4, s4}), 64'(exp4));
  end

  task automatic drive(input logic v, input logic a1, input logic b1,
                       input logic [3:0] a4, input logic [3:0] b4, input logic c);
    @(posedge clk);
    #2;
    in_valid = v;
    x1 = a1; y1 = b1;
    x4 = a4; y4 = b4;
    cin = c;
  endtask

  task automatic settle();
    repeat (LAT) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset_vld", 64'({ov1, ov4}), 64'(0));
    check("reset_sum", 64'({cout1, s1, cout4, s4}), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    settle();
    check("zero_sum1", 64'({ov1, cout1, s1}), 64'(3'b100));

    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    settle();
    check("one_one1", 64'({ov1, cout1, s1}), 64'(3'b110));

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive(1'b1, v[2], v[1], 4'h0, 4'h0, v[0]);
      settle();
      check("sweep1", 64'({cout1, s1}), 64'(2'(v[2]) + 2'(v[1]) + 2'(v[0])));
      if (v == 3'b101) check("sweep_101", 64'({cout1, s1}), 64'(2'b10));
      if (v == 3'b111) check("sweep_111", 64'({ov1, cout1, s1}), 64'(3'b111));
    end

    drive(1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1);
    settle();
    check("f_plus_c4", 64'({ov4, cout4, s4}), 64'(6'b110000));

    drive(1'b1, 1'b0, 1'b0, 4'h3, 4'h4, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
    settle();
    check("hold_sum4", 64'({ov4, cout4, s4}), 64'(6'b000111));
    drive(1'b1, 1'b0, 1'b0, 4'h2, 4'h5, 1'b1);
    settle();
    check("resume_sum4", 64'({ov4, cout4, s4}), 64'(6'b101000));

    for (int n = 0; n < 1000; n++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom));
    end

    drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_async_vld", 64'({ov1, ov4}), 64'(0));
    check("rst_async_sum", 64'({cout1, s1, cout4, s4}), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("no_pulse_after_rst", 64'({ov1, ov4}), 64'(0));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/full_adder_structure.md
FULL_ADDER_STRUCTURE -- requirements
Module: full_adder_structure

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Parameter WIDTH, default 1, SHALL set the operand and sum width in bits; legal range is 1..64.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port x, input, WIDTH bits: addend A.
REQ-006 Port y, input, WIDTH bits: addend B.
REQ-007 Port cin, input, 1 bit: carry in.
REQ-008 Port in_valid, input, 1 bit: x, y and cin are valid this cycle.
REQ-009 Port cout, output, 1 bit: registered carry out.
REQ-010 Port s, output, WIDTH bits: registered sum.
REQ-011 Port out_valid, output, 1 bit: cout and s hold a valid result.

Function
REQ-012 The block SHALL compute {cout, s} = x + y + cin as an unsigned value of WIDTH+1 bits, with no truncation.
- Examples: 1+1+0 gives cout=1, s=0; 1+1+1 gives cout=1, s=1.
REQ-013 Bit i of the combinational result SHALL be built from two half-adder cells and one OR:
- s_i = x_i ^ y_i ^ c_i
- c_(i+1) = (x_i & y_i) | (c_i & (x_i ^ y_i))
- c_0 = cin; cout = c_WIDTH (ripple carry).
REQ-014 The result SHALL be captured on the rising clk edge when in_valid=1; with the default build, latency is 1 cycle from the input edge to the output.
REQ-015 out_valid SHALL equal in_valid delayed by the same latency as the result.
REQ-016 When in_valid=0, cout and s SHALL hold their previous values.
REQ-017 X or Z on any input bit that affects the result SHALL propagate as X to the affected outputs; no X-masking logic.
REQ-018 There SHALL be no backpressure; a new operand set may be accepted every cycle.

Reset
REQ-019 While rst=1, cout SHALL be 0, s SHALL be all zeros and out_valid SHALL be 0, independent of clk.
REQ-020 Any operation in flight when rst asserts SHALL be discarded; no output pulse SHALL follow its deassertion.
REQ-021 The first capture after reset SHALL occur at the first rising clk edge with rst=0 and in_valid=1.

Configuration
REQ-022 Macro FULL_ADDER_STRUCTURE_INREG_EN SHALL, when defined, insert an input register stage on x, y, cin and in_valid.
- The input stage resets to 0.
- Total latency becomes 2 cycles.
REQ-023 When FULL_ADDER_STRUCTURE_INREG_EN is undefined, the adder SHALL be fed directly from the ports with 1-cycle latency; function is otherwise identical.

Structure
REQ-024 A package full_adder_structure_pkg SHALL hold:
- constant FAS_DEFAULT_WIDTH = 1;
- constants FAS_LATENCY_BASE = 1 and FAS_LATENCY_INREG = 2.
REQ-025 One sub-module, half_adder (inputs a, b; outputs s = a^b, c = a&b), SHALL be instantiated 2*WIDTH times through a generate loop.
REQ-026 The adder datapath SHALL use gate-level or continuous-assignment logic only; a behavioural "+" SHALL NOT be used in the datapath.

Verification
REQ-027 WIDTH=1, reset released, in_valid=1:
- x=0, y=0, cin=0 -> next cycle cout=0, s=0, out_valid=1;
- x=1, y=1, cin=0 -> cout=1, s=0.
REQ-028 WIDTH=1, exhaustive sweep of all 8 input combinations -> {cout, s} equals the arithmetic sum for each, e.g. 1+0+1 -> cout=1, s=0.
REQ-029 WIDTH=4, x=4'hF, y=4'h0, cin=1 -> cout=1, s=4'h0; random x, y, cin over 1000 cycles match the reference model x+y+cin.
REQ-030 in_valid=1 at cycle 3, then rst asserted mid-cycle before the cycle-4 edge -> cout=0, s=0 and out_valid=0 immediately, with no valid pulse after release.
REQ-031 in_valid toggling 1,0,1 -> outputs update only on valid cycles and hold otherwise.
REQ-032 With FULL_ADDER_STRUCTURE_INREG_EN defined, x=1, y=1, cin=1 -> cout=1, s=1 and out_valid=1 exactly two edges later.
